// File: rtl/mmu_pkg.sv
// Shared Sv32 MMU definitions: PTE bit positions, PTE classification and
// page-table-walker state encoding. The TLB uses the same perm ordering.
package mmu_pkg;
  localparam int PTE_V        = 0;
  localparam int PTE_R        = 1;
  localparam int PTE_W        = 2;
  localparam int PTE_X        = 3;
  localparam int PTE_U        = 4;
  localparam int PTE_G        = 5;
  localparam int PTE_A        = 6;
  localparam int PTE_D        = 7;
  localparam int PTE_PPN0_LSB = 10;
  localparam int PTE_PPN0_MSB = 19;
  localparam int PTE_PPN1_LSB = 20;
  localparam int PTE_PPN1_MSB = 31;

  typedef enum logic [1:0] {
    PTE_INVALID,
    PTE_POINTER,
    PTE_LEAF,
    PTE_MISALIGNED
  } pte_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_L1,
    ST_L0,
    ST_DONE,
    ST_DRAIN
  } ptw_state_e;

  // Byte address of a 4-byte PTE; only the low 20 bits of the table PPN
  // reach the 32-bit physical bus.
  function automatic logic [31:0] pte_addr(input logic [21:0] a,
                                           input logic [9:0]  vpn_x);
    return {a[19:0], 12'h000} + {20'h0, vpn_x, 2'b00};
  endfunction
endpackage

// File: rtl/ptw_pte_decode.sv
// Combinational Sv32 PTE classifier: invalid / pointer / leaf / misaligned
// superpage, plus the next-level PPN and the 7-bit permission field.
module ptw_pte_decode
  import mmu_pkg::*;
(
  input  logic [31:0] i_pte,
  input  logic        i_level,  // 1 = first-level (superpage) lookup
  output pte_class_e  o_class,
  output logic [21:0] o_ppn,
  output logic [6:0]  o_perm
);
  logic w_leaf;
  logic w_unused_rsw;

  assign w_leaf       = i_pte[PTE_R] | i_pte[PTE_X];
  assign w_unused_rsw = ^i_pte[9:8];
  assign o_ppn  = {i_pte[PTE_PPN1_MSB:PTE_PPN1_LSB], i_pte[PTE_PPN0_MSB:PTE_PPN0_LSB]};
  assign o_perm = {i_pte[PTE_D], i_pte[PTE_A], i_pte[PTE_G], i_pte[PTE_U],
                   i_pte[PTE_X], i_pte[PTE_W], i_pte[PTE_R]};

  // A pointer is only legal at the first level and must not carry D/A/U.
  always_comb begin
    o_class = PTE_INVALID;
    if (!i_pte[PTE_V] || (!i_pte[PTE_R] && i_pte[PTE_W])) begin
      o_class = PTE_INVALID;
    end else if (w_leaf) begin
      if (i_level && (i_pte[PTE_PPN0_MSB:PTE_PPN0_LSB] != 10'h0)) o_class = PTE_MISALIGNED;
      else                                                      o_class = PTE_LEAF;
    end else if (i_level && !(i_pte[PTE_D] || i_pte[PTE_A] || i_pte[PTE_U])) begin
      o_class = PTE_POINTER;
    end
  end
endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker: one two-level walk at a time, delivering a
// TLB fill or a page/access fault. Valid/ready: a request is taken on any
// cycle where req_valid_i and req_ready_o are both high at the clock edge.
module sv32_ptw
  import mmu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_vaddr_i,
  input  logic        satp_mode_i,
  input  logic [21:0] satp_ppn_i,
  input  logic        abort_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        fill_req_o,
  output logic [19:0] fill_vpn_o,
  output logic [21:0] fill_ppn_o,
  output logic [6:0]  fill_perm_o,
  output logic        fill_superpage_o,
  output logic        done_o,
  output logic        page_fault_o,
  output logic        access_fault_o,
  output logic [2:0]  dbg_state_o
);
  ptw_state_e  r_state, w_state_nxt;
  logic [19:0] r_vpn;
  logic [31:0] r_mem_addr, w_addr_nxt;
  logic        r_done, r_fill, r_pf, r_af;
  logic [19:0] r_fill_vpn;
  logic [21:0] r_fill_ppn;
  logic [6:0]  r_fill_perm;
  logic        r_fill_sp;
  logic        w_finish, w_fill, w_pf, w_af, w_sp;
  pte_class_e  w_class;
  logic [21:0] w_ppn;
  logic [6:0]  w_perm;
  logic        w_unused_offset;

  assign w_unused_offset = ^req_vaddr_i[11:0];

  ptw_pte_decode u_decode (
    .i_pte   (mem_rdata_i),
    .i_level (r_state == ST_L1),
    .o_class (w_class),
    .o_ppn   (w_ppn),
    .o_perm  (w_perm)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_mem_addr;
    w_finish    = 1'b0;
    w_fill      = 1'b0;
    w_pf        = 1'b0;
    w_af        = 1'b0;
    w_sp        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid_i) begin
          if (!satp_mode_i) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
          end else if (satp_ppn_i[21:20] != 2'b00) begin
            w_state_nxt = ST_DONE;
            w_finish    = 1'b1;
            w_af        = 1'b1;
          end else begin
            w_state_nxt = ST_L1;
            w_addr_nxt  = pte_addr(satp_ppn_i, req_vaddr_i[31:22]);
          end
        end
      end
      ST_L1, ST_L0: begin
        if (mem_ack_i && abort_i) begin
          w_state_nxt = ST_IDLE;
        end else if (mem_ack_i) begin
          case (w_class)
            PTE_LEAF: begin
              w_state_nxt = ST_DONE;
              w_finish    = 1'b1;
              w_fill      = 1'b1;
              w_sp        = (r_state == ST_L1);
            end
            PTE_POINTER: begin
              if (w_ppn[21:20] != 2'b00) begin
                w_state_nxt = ST_DONE;
                w_finish    = 1'b1;
                w_af        = 1'b1;
              end else begin
                w_state_nxt = ST_L0;
                w_addr_nxt  = pte_addr(w_ppn, r_vpn[9:0]);
              end
            end
            default: begin
              w_state_nxt = ST_DONE;
              w_finish    = 1'b1;
              w_pf        = 1'b1;
            end
          endcase
        end else if (abort_i) begin
          // The outstanding read cannot be cancelled; wait it out in DRAIN.
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      ST_DRAIN: if (mem_ack_i) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_vpn       <= '0;
      r_mem_addr  <= '0;
      r_done      <= 1'b0;
      r_fill      <= 1'b0;
      r_pf        <= 1'b0;
      r_af        <= 1'b0;
      r_fill_vpn  <= '0;
      r_fill_ppn  <= '0;
      r_fill_perm <= '0;
      r_fill_sp   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_addr <= w_addr_nxt;
      r_done     <= w_finish;
      r_fill     <= w_fill;
      r_pf       <= w_pf;
      r_af       <= w_af;
      if (r_state == ST_IDLE && req_valid_i) r_vpn <= req_vaddr_i[31:12];
      if (w_fill) begin
        r_fill_vpn  <= r_vpn;
        r_fill_ppn  <= w_ppn;
        r_fill_perm <= w_perm;
        r_fill_sp   <= w_sp;
      end
    end
  end

  assign req_ready_o      = (r_state == ST_IDLE);
  assign mem_req_o        = (r_state == ST_L1) || (r_state == ST_L0) || (r_state == ST_DRAIN);
  assign mem_addr_o       = r_mem_addr;
  // An abort landing on the DONE cycle cancels the completion strobes.
  assign done_o           = r_done & ~abort_i;
  assign fill_req_o       = r_fill & ~abort_i;
  assign page_fault_o     = r_pf;
  assign access_fault_o   = r_af;
  assign fill_vpn_o       = r_fill_vpn;
  assign fill_ppn_o       = r_fill_ppn;
  assign fill_perm_o      = r_fill_perm;
  assign fill_superpage_o = r_fill_sp;
  assign dbg_state_o      = r_state;
endmodule

// File: tb/tb_sv32_ptw.sv
// Bench for sv32_ptw: table of walks against a wait-state memory model,
// plus hand sequences for aborts, abort on DONE and reset mid-walk.
module tb_sv32_ptw;
  import mmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i;
  logic        satp_mode_i;
  logic [21:0] satp_ppn_i;
  logic        abort_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        fill_req_o;
  logic [19:0] fill_vpn_o;
  logic [21:0] fill_ppn_o;
  logic [6:0]  fill_perm_o;
  logic        fill_superpage_o;
  logic        done_o;
  logic        page_fault_o;
  logic        access_fault_o;
  logic [2:0]  dbg_state_o;

  sv32_ptw dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_vaddr_i      (req_vaddr_i),
    .satp_mode_i      (satp_mode_i),
    .satp_ppn_i       (satp_ppn_i),
    .abort_i          (abort_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rdata_i      (mem_rdata_i),
    .fill_req_o       (fill_req_o),
    .fill_vpn_o       (fill_vpn_o),
    .fill_ppn_o       (fill_ppn_o),
    .fill_perm_o      (fill_perm_o),
    .fill_superpage_o (fill_superpage_o),
    .done_o           (done_o),
    .page_fault_o     (page_fault_o),
    .access_fault_o   (access_fault_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory model: acks after mem_waits cycles of a held request.
  logic [31:0] cur_a1, cur_d1, cur_a0, cur_d0;
  int          mem_waits;
  logic        stray_ack;
  int          wait_cnt = 0;
  int          n_ack = 0;
  logic [31:0] addr_log[$];

  always @(negedge clk) begin
    if (stray_ack) begin
      mem_ack_i   <= 1'b1;
      mem_rdata_i <= 32'h0010_00CF;
      wait_cnt    <= 0;
    end else if (mem_req_o && wait_cnt >= mem_waits) begin
      mem_ack_i   <= 1'b1;
      mem_rdata_i <= (mem_addr_o == cur_a1) ? cur_d1 :
                     (mem_addr_o == cur_a0) ? cur_d0 : 32'h0;
      wait_cnt    <= 0;
      n_ack       <= n_ack + 1;
      addr_log.push_back(mem_addr_o);
    end else begin
      mem_ack_i   <= 1'b0;
      mem_rdata_i <= 32'h0;
      wait_cnt    <= mem_req_o ? wait_cnt + 1 : 0;
    end
  end

  typedef struct {
    logic        mode;
    logic [21:0] satp;
    logic [31:0] vaddr;
    logic [31:0] a1, d1, a0, d0;
    int          waits, nreq, lat;
    logic        fill, pf, af, sp;
    logic [21:0] ppn;
    logic [6:0]  perm;
  } vec_t;

  vec_t        vecs[12];
  logic [52:0] exp_q[$];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [52:0] pack_res(input logic fill, input logic pf, input logic af,
                                           input logic sp, input logic [19:0] vpn,
                                           input logic [21:0] ppn, input logic [6:0] perm);
    return fill ? {fill, pf, af, sp, vpn, ppn, perm} : {1'b0, pf, af, 50'b0};
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {req_ready_o, mem_req_o, fill_req_o, done_o, page_fault_o,
                         access_fault_o, fill_superpage_o}, 64'h40);
    chk({tag, "_addr_vpn"}, {mem_addr_o, fill_vpn_o}, 64'h0);
    chk({tag, "_ppn_perm"}, {fill_ppn_o, fill_perm_o}, 64'h0);
    chk({tag, "_state"}, dbg_state_o, ST_IDLE);
  endtask

  task automatic set_mem(input vec_t v);
    cur_a1 = v.a1; cur_d1 = v.d1; cur_a0 = v.a0; cur_d0 = v.d0;
    mem_waits = v.waits;
  endtask

  // Driver: issue one walk; scoreboard entry pushed at accept, popped at done.
  task automatic run_vec(input vec_t v);
    int base_n, base_q, cyc;
    logic [52:0] exp_r;
    set_mem(v);
    base_n = n_ack;
    base_q = addr_log.size();
    req_valid_i = 1'b1;
    req_vaddr_i = v.vaddr;
    satp_mode_i = v.mode;
    satp_ppn_i  = v.satp;
    chk("ready_idle", req_ready_o, 1);
    exp_q.push_back(pack_res(v.fill, v.pf, v.af, v.sp, v.vaddr[31:12], v.ppn, v.perm));
    tick();
    req_valid_i = 1'b0;
    cyc = 1;
    chk("busy_not_ready", req_ready_o, 0);
    while (!done_o && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("done_seen", done_o, 1);
    exp_r = exp_q.pop_front();
    if (done_o) begin
      chk("walk_result", pack_res(fill_req_o, page_fault_o, access_fault_o, fill_superpage_o,
                                  fill_vpn_o, fill_ppn_o, fill_perm_o), exp_r);
      chk("walk_latency", cyc, v.lat);
    end
    chk("mem_req_count", n_ack - base_n, v.nreq);
    if (v.nreq >= 1 && addr_log.size() > base_q)     chk("l1_addr", addr_log[base_q], v.a1);
    if (v.nreq >= 2 && addr_log.size() > base_q + 1) chk("l0_addr", addr_log[base_q + 1], v.a0);
    tick();
    chk("ready_after_done", {req_ready_o, done_o}, 2'b10);
  endtask

  // Abort one cycle after accept with the given L1 wait states.
  task automatic abort_seq(input int waits);
    int cyc, base_n;
    logic bad_hold, bad_out;
    set_mem(vecs[0]);
    mem_waits = waits;
    base_n = n_ack;
    bad_hold = 1'b0;
    bad_out  = 1'b0;
    req_valid_i = 1'b1; req_vaddr_i = 32'h4000_1234; satp_mode_i = 1'b1; satp_ppn_i = 22'h80;
    tick();
    req_valid_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    cyc = 2;
    while (!req_ready_o && cyc < 30) begin
      if (!mem_req_o || mem_addr_o != 32'h0008_0400) bad_hold = 1'b1;
      if (done_o || fill_req_o) bad_out = 1'b1;
      tick();
      cyc++;
    end
    chk("abort_req_held", bad_hold, 0);
    chk("abort_ready_cycle", cyc, waits + 2);
    chk("abort_mem_idle", mem_req_o, 0);
    chk("abort_one_read", n_ack - base_n, 1);
    for (int i = 0; i < 3; i++) begin
      if (done_o || fill_req_o) bad_out = 1'b1;
      tick();
    end
    chk("abort_no_done", bad_out, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic bad;
    rst = 1'b1; req_valid_i = 1'b0; req_vaddr_i = '0; satp_mode_i = 1'b0; satp_ppn_i = '0;
    abort_i = 1'b0; stray_ack = 1'b0; mem_waits = 0;
    cur_a1 = '0; cur_d1 = '0; cur_a0 = '0; cur_d0 = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    //          mode satp        vaddr          a1            d1            a0            d0            w  n  lat fill pf af sp ppn       perm
    vecs[0]  = '{1'b1, 22'h80,     32'h4000_1234, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h048D_14CF, 0, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 22'h12345, 7'h67};
    vecs[1]  = vecs[0];
    vecs[1].waits = $urandom_range(1, 3);
    vecs[1].lat   = 3 + 2 * vecs[1].waits;
    vecs[2]  = '{1'b1, 22'h80,     32'h8040_0000, 32'h0008_0804, 32'h0010_00CF, 32'hFFFF_FFFF, 32'h0,         0, 1, 2, 1'b1, 1'b0, 1'b0, 1'b1, 22'h00400, 7'h67};
    vecs[3]  = vecs[2];
    vecs[3].waits = 1;
    vecs[3].lat   = 3;
    vecs[4]  = '{1'b1, 22'h80,     32'h8040_0000, 32'h0008_0804, 32'h0010_04CF, 32'hFFFF_FFFF, 32'h0,         0, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0,     7'h0};
    vecs[5]  = '{1'b1, 22'h80,     32'h4000_1234, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h0000_0000, 0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0,     7'h0};
    vecs[6]  = '{1'b1, 22'h80,     32'h4000_1234, 32'h0008_0400, 32'h4000_0001, 32'hFFFF_FFFF, 32'h0,         0, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0,     7'h0};
    vecs[7]  = '{1'b0, 22'h80,     32'h4000_1234, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'h0,         0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h0,     7'h0};
    vecs[8]  = '{1'b1, 22'h100080, 32'h4000_1234, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'h0,         0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 22'h0,     7'h0};
    vecs[9]  = '{1'b1, 22'h80,     32'h4000_1234, 32'h0008_0400, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0,         0, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0,     7'h0};
    vecs[10] = '{1'b1, 22'h80,     32'h4000_1234, 32'h0008_0400, 32'h0002_0441, 32'hFFFF_FFFF, 32'h0,         0, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0,     7'h0};
    vecs[11] = '{1'b1, 22'h80,     32'h4000_1234, 32'h0008_0400, 32'h0002_0401, 32'h0008_1004, 32'h0002_0401, 0, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0, 22'h0,     7'h0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_reset("reset");

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    abort_seq(3);
    abort_seq(0);

    // Abort arriving on the DONE cycle of a superpage walk.
    set_mem(vecs[2]);
    req_valid_i = 1'b1; req_vaddr_i = 32'h8040_0000; satp_mode_i = 1'b1; satp_ppn_i = 22'h80;
    tick();
    req_valid_i = 1'b0;
    tick();
    chk("abort_done_state", dbg_state_o, ST_DONE);
    abort_i = 1'b1;
    #1;
    chk("abort_done_strobes", {done_o, fill_req_o}, 2'b00);
    tick();
    abort_i = 1'b0;
    chk("abort_done_ready", {req_ready_o, done_o}, 2'b10);

    // Reset asserted while waiting on the L0 read, then a stray late ack.
    run_vec(vecs[0]);
    set_mem(vecs[0]);
    mem_waits = 3;
    req_valid_i = 1'b1; req_vaddr_i = 32'h4000_1234; satp_mode_i = 1'b1; satp_ppn_i = 22'h80;
    tick();
    req_valid_i = 1'b0;
    cyc = 1;
    while (mem_addr_o != 32'h0008_1004 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("l0_reached", {mem_req_o, dbg_state_o}, {1'b1, ST_L0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset("rst_mid_walk");
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done_o || fill_req_o || mem_req_o || !req_ready_o) bad = 1'b1;
    end
    chk("late_ack_ignored", bad, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sv32_ptw.md
# sv32_ptw

Hardware page-table walker for the Sv32 MMU. On a TLB miss it walks the two-level Sv32 page table in memory and delivers a translation to the TLB fill interface (`fill_req`/`fill_vpn`/`fill_ppn`/`fill_perm`/`fill_superpage`), or reports a page or access fault. It sits between the MMU miss logic, the 32-entry TLB and a single-port memory read port, and handles one walk at a time.

## Interface
- No parameters (Sv32 geometry fixed: 2 levels, 4-byte PTEs, 32-bit physical bus).
- `clk` in 1 — clock
- `rst` in 1 — synchronous, active-high reset
- `req_valid_i` in 1 — walk request
- `req_ready_o` out 1 — high only in IDLE
- `req_vaddr_i` in 32 — missing virtual address
- `satp_mode_i` in 1 — 1 = Sv32, 0 = bare
- `satp_ppn_i` in 22 — root table PPN, sampled at accept
- `abort_i` in 1 — SFENCE.VMA or context change; kill current walk
- `mem_req_o` out 1 — PTE read request
- `mem_addr_o` out 32 — PTE byte address
- `mem_ack_i` in 1 — read complete; may be asserted in the same cycle as the request
- `mem_rdata_i` in 32 — PTE, valid while `mem_ack_i` is high
- `fill_req_o` out 1 — one-cycle TLB fill strobe
- `fill_vpn_o` out 20, `fill_ppn_o` out 22, `fill_perm_o` out 7 {D,A,G,U,X,W,R}, `fill_superpage_o` out 1
- `done_o` out 1 — one-cycle walk completion
- `page_fault_o` out 1, `access_fault_o` out 1 — qualified by `done_o`

## Operation
- States: IDLE, L1, L0, DONE, DRAIN.
- **IDLE**
  - On `req_valid_i && req_ready_o`: latch VPN = vaddr[31:12] and `a = satp_ppn_i`.
  - If `satp_mode_i = 0`: go to DONE with no fill and no fault.
  - Otherwise go to L1.
- **PTE address**
  - Formed as `{a[19:0],12'h000} + {vpnX,2'b00}`.
  - If `a[21:20] != 0`, no request is issued: go to DONE with `access_fault`.
- **L1**
  - `mem_req_o = 1`. Address and request are held stable until ack.
  - On ack, decode the PTE and set the result:
    - V=0, or R=0 with W=1: page fault.
    - Leaf (R|X) with PTE[19:10] != 0: page fault (misaligned superpage).
    - Leaf, otherwise: superpage fill, ppn = PTE[31:10].
    - Pointer (R=X=0) with any of D/A/U set: page fault.
    - Pointer, otherwise: `a = PTE[31:10]`, go to L0.
- **L0**
  - Request as in L1, using vpn0.
  - On ack:
    - V=0, or R=0 with W=1, or non-leaf: page fault.
    - Otherwise: regular fill, ppn = PTE[31:10].
- **Fill fields**
  - perm = PTE[7:1].
  - `fill_vpn_o` = latched VPN.
  - The PTW never checks R/W/X/U permissions or A/D bits; the MMU does that from `perm_o`.
- **DONE**
  - Lasts one cycle: `done_o = 1`.
  - `fill_req_o = 1` only if no fault and not bare mode.
  - Then IDLE.
- **Abort**
  - In IDLE: ignored.
  - In L1/L0 with no ack this cycle: go to DRAIN. `mem_req_o` stays high with the same address until ack, then IDLE. The data is discarded; no done, no fill.
  - In L1/L0 in the same cycle as ack: go to IDLE directly.
  - In DONE: suppresses `done_o` and `fill_req_o`.
- Fault flags are mutually exclusive. All `fill_*`, fault and `done` outputs are registered.

## Timing
- Reset values:
  - State IDLE, so `req_ready_o = 1`.
  - `mem_req_o`, `fill_req_o`, `done_o` and both fault flags = 0.
  - `mem_addr_o` and `fill_*` = 0.
- Reset mid-walk:
  - `mem_req_o` drops on the next edge.
  - A later ack is ignored in IDLE; the memory side must tolerate a dropped request.
- Latency with zero-wait memory (accept at cycle 0):
  - Superpage or L1 fault: DONE in cycle 2.
  - Regular page: DONE in cycle 3.
  - Each memory wait cycle adds one.
- A new request is accepted no earlier than the cycle after DONE (or DRAIN) exits.

## Structure
- Shared package `mmu_pkg`: PTE bit-position constants (V, R, W, X, U, G, A, D, PPN1, PPN0), PTE-class enum {INVALID, POINTER, LEAF, MISALIGNED}, PTW state enum. The TLB uses the same perm ordering.
- Sub-module `ptw_pte_decode` (combinational): inputs PTE and level; outputs class, next PPN and perm.

## Test plan
- **Regular page:** satp_ppn=0x00080, vaddr 0x4000_1234. Read of 0x0008_0400 returns 0x0002_0401; read of 0x0008_1004 returns 0x048D_14CF. Expect `fill_vpn`=0x40001, `fill_ppn`=0x12345, `fill_perm`=0x67, superpage=0, `done` in cycle 3.
- **Superpage:** vaddr 0x8040_0000. Read of 0x0008_0804 returns 0x0010_00CF. Expect `fill_superpage`=1, `fill_ppn`=0x00400, only one memory request, `done` in cycle 2.
- **Misaligned superpage / invalid L0:** L1 PTE 0x0010_04CF gives `page_fault`, no fill. Valid pointer followed by L0 PTE 0x0000_0000 gives `page_fault`, no fill.
- **Access fault:** L1 pointer PTE 0x4000_0001 (ppn bit 20 set). Expect `access_fault`, no L0 request issued.
- **Abort during wait:** `abort_i` pulsed while L1 ack has 3 wait states. `mem_req_o` and address held until ack, then IDLE; no `done`/`fill`; `req_ready_o` high the following cycle.
- **Bare mode and reset:** `satp_mode_i`=0 gives `done` with no fill and no fault. `rst` asserted in L0 gives all outputs at reset values next cycle, and a late ack is ignored.
